// File: rtl/pc_sequencer.sv
// pc_sequencer: sequence counter, T0..T15 decode and PC INR/LD/CLR control for the basic-computer cycle.
// Define INTR_EN to build the interrupt cycle (R flag, RT0..RT2); otherwise R and PC_CLR stay 0.
module pc_sequencer #(
  parameter int unsigned SC_W    = 4,
  parameter logic [11:0] INT_VEC = 12'h000
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [15:0]           IR,
  input  logic                  AC_SIGN,
  input  logic                  AC_ZERO,
  input  logic                  E_ZERO,
  input  logic                  DR_ZERO,
  input  logic                  FGI,
  input  logic                  FGO,
  output logic [(1<<SC_W)-1:0]  T,
  output logic [SC_W-1:0]       SC,
  output logic                  RUN,
  output logic                  IR_LD,
  output logic                  AR_LD_PC,
  output logic                  PC_INR,
  output logic                  PC_LD,
  output logic                  PC_CLR,
  output logic                  IEN,
  output logic                  R
);

  localparam int unsigned T_W = 1 << SC_W;

  typedef enum logic [1:0] {
    K_MRI,
    K_RRI,
    K_IO
  } kind_e;

  logic [SC_W-1:0] sc_q, sc_d;
  logic            run_q, run_d;
  logic            ien_q, ien_d;
  logic [T_W-1:0]  t_dec;
  logic [7:0]      d;
  logic            ind;
  logic            r_cyc;
  kind_e           kind;

  logic ar_ld, ir_ld, inr_req, ld_req, clr_req, sc_clr;

  // INT_VEC is applied by the PC itself; IR[11:10] and IR[5] carry no control meaning here.
  logic unused_bits;
  assign unused_bits = ^{INT_VEC, IR[11:10], IR[5]};

  assign ind = IR[15];

  always_comb begin
    t_dec       = '0;
    t_dec[sc_q] = 1'b1;
  end

  always_comb begin
    d           = '0;
    d[IR[14:12]] = 1'b1;
  end

  always_comb begin
    if (!d[7])    kind = K_MRI;
    else if (ind) kind = K_IO;
    else          kind = K_RRI;
  end

`ifdef INTR_EN
  logic r_q, r_d;
  assign r_cyc = r_q;
`else
  assign r_cyc = 1'b0;
`endif

  always_comb begin
    sc_d    = sc_q;
    run_d   = run_q;
    ien_d   = ien_q;
    ar_ld   = 1'b0;
    ir_ld   = 1'b0;
    inr_req = 1'b0;
    ld_req  = 1'b0;
    clr_req = 1'b0;
    sc_clr  = 1'b0;

    if (run_q) begin
      if (r_cyc) begin
        if (t_dec[1]) clr_req = 1'b1;
        if (t_dec[2]) begin
          inr_req = 1'b1;
          ien_d   = 1'b0;
          sc_clr  = 1'b1;
        end
      end else begin
        if (t_dec[0]) ar_ld = 1'b1;
        if (t_dec[1]) begin
          ir_ld   = 1'b1;
          inr_req = 1'b1;
        end
        if (t_dec[3]) begin
          case (kind)
            K_RRI: begin
              // OR of all satisfied skips: one increment however many conditions hold
              inr_req = (IR[4] & ~AC_SIGN) | (IR[3] & AC_SIGN) |
                        (IR[2] & AC_ZERO)  | (IR[1] & E_ZERO);
              if (IR[0]) run_d = 1'b0;
              sc_clr = 1'b1;
            end
            K_IO: begin
              inr_req = (IR[9] & FGI) | (IR[8] & FGO);
              if (IR[7]) ien_d = 1'b1;
              if (IR[6]) ien_d = 1'b0;
              sc_clr = 1'b1;
            end
            default: ;
          endcase
        end
        if (t_dec[4] && d[4]) begin
          ld_req = 1'b1;
          sc_clr = 1'b1;
        end
        if (t_dec[4] && d[3]) sc_clr = 1'b1;
        if (t_dec[5] && d[5]) begin
          ld_req = 1'b1;
          sc_clr = 1'b1;
        end
        if (t_dec[5] && (d[0] || d[1] || d[2])) sc_clr = 1'b1;
        if (t_dec[6] && d[6]) begin
          inr_req = DR_ZERO;
          sc_clr  = 1'b1;
        end
      end
      sc_d = sc_clr ? '0 : sc_q + SC_W'(1);
    end
  end

`ifdef INTR_EN
  always_comb begin
    r_d = r_q;
    if (run_q) begin
      if (r_q && t_dec[2])
        r_d = 1'b0;
      else if (!r_q && !(t_dec[0] || t_dec[1] || t_dec[2]) && ien_q && (FGI || FGO))
        r_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_q <= 1'b0;
    else      r_q <= r_d;
  end
`endif

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sc_q  <= '0;
      run_q <= 1'b1;
      ien_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      run_q <= run_d;
      ien_q <= ien_d;
    end
  end

  // Controls are held low while reset is asserted, even though T0 is decoded.
  assign AR_LD_PC = CLR & ar_ld;
  assign IR_LD    = CLR & ir_ld;
  assign PC_LD    = CLR & ld_req;
  assign PC_CLR   = CLR & clr_req;
  assign PC_INR   = CLR & inr_req & ~ld_req & ~clr_req;

  assign T   = t_dec;
  assign SC  = sc_q;
  assign RUN = run_q;
  assign IEN = ien_q;
  assign R   = r_cyc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_pc_sequencer;

  logic        CLK, CLR;
  logic [15:0] IR;
  logic        AC_SIGN, AC_ZERO, E_ZERO, DR_ZERO, FGI, FGO;
  logic [15:0] T;
  logic [3:0]  SC;
  logic        RUN, IR_LD, AR_LD_PC, PC_INR, PC_LD, PC_CLR, IEN, R;

  pc_sequencer #(.SC_W(4), .INT_VEC(12'h000)) dut (
    .CLK(CLK), .CLR(CLR), .IR(IR),
    .AC_SIGN(AC_SIGN), .AC_ZERO(AC_ZERO), .E_ZERO(E_ZERO), .DR_ZERO(DR_ZERO),
    .FGI(FGI), .FGO(FGO),
    .T(T), .SC(SC), .RUN(RUN), .IR_LD(IR_LD), .AR_LD_PC(AR_LD_PC),
    .PC_INR(PC_INR), .PC_LD(PC_LD), .PC_CLR(PC_CLR), .IEN(IEN), .R(R)
  );

  // ctl order: {AR_LD_PC, IR_LD, PC_INR, PC_LD, PC_CLR}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_AR    = 5'b10000;
  localparam logic [4:0] C_FETCH = 5'b01100;
  localparam logic [4:0] C_INR   = 5'b00100;
  localparam logic [4:0] C_LD    = 5'b00010;
  localparam logic [4:0] C_CLR   = 5'b00001;

  typedef struct {
    string      name;
    logic [3:0] sc;
    logic       run;
    logic [4:0] ctl;
    logic       ien;
    logic       r;
  } exp_t;

  exp_t        q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic        ien_e = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic expect_cyc(input string nm, input logic [3:0] sc, input logic [4:0] ctl,
                            input logic run = 1'b1, input logic r = 1'b0);
    exp_t e;
    e.name = nm;
    e.sc   = sc;
    e.run  = run;
    e.ctl  = ctl;
    e.ien  = ien_e;
    e.r    = r;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Fetch T0..T2, then T3..last with act_ctl on cycle act_t (0 = no execute activity).
  task automatic instr(input string nm, input logic [15:0] ir, input int unsigned last,
                       input int unsigned act_t, input logic [4:0] act_ctl);
    IR = ir;
    expect_cyc($sformatf("%s.t0", nm), 4'd0, C_AR);
    expect_cyc($sformatf("%s.t1", nm), 4'd1, C_FETCH);
    for (int unsigned t = 2; t <= last; t++)
      expect_cyc($sformatf("%s.t%0d", nm, t), 4'(t), (t == act_t) ? act_ctl : C_NONE);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] one;
    logic [27:0] act, exp;
    one = 16'h0001;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {SC, T, RUN, AR_LD_PC, IR_LD, PC_INR, PC_LD, PC_CLR, IEN, R};
        exp = {e.sc, one << e.sc, e.run, e.ctl, e.ien, e.r};
        n_vec++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL %s: got sc=%0d t=%h run=%b ctl=%b ien=%b r=%b, want sc=%0d t=%h run=%b ctl=%b ien=%b r=%b",
                   e.name, SC, T, RUN, {AR_LD_PC, IR_LD, PC_INR, PC_LD, PC_CLR}, IEN, R,
                   e.sc, one << e.sc, e.run, e.ctl, e.ien, e.r);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d want 0", q.size());
    $fatal(1);
  end

  initial begin : stimulus
    CLR = 1'b1;
    IR = 16'h7800;
    AC_SIGN = 1'b0; AC_ZERO = 1'b0; E_ZERO = 1'b0; DR_ZERO = 1'b0; FGI = 1'b0; FGO = 1'b0;
    #2 CLR = 1'b0;
    @(posedge CLK);
    #1;
    expect_cyc("rst0", 4'd0, C_NONE);
    expect_cyc("rst1", 4'd0, C_NONE);
    CLR = 1'b1;

    instr("cla", 16'h7800, 3, 0, C_NONE);
    instr("cla2", 16'h7800, 3, 0, C_NONE);

    AC_ZERO = 1'b1;
    instr("sza_z", 16'h7004, 3, 3, C_INR);
    AC_ZERO = 1'b0;
    instr("sza_nz", 16'h7004, 3, 0, C_NONE);
    AC_SIGN = 1'b1;
    instr("sna_neg", 16'h7008, 3, 3, C_INR);
    instr("spa_neg", 16'h7010, 3, 0, C_NONE);
    AC_SIGN = 1'b0;
    instr("sna_pos", 16'h7008, 3, 0, C_NONE);
    AC_ZERO = 1'b1; E_ZERO = 1'b1;
    instr("multi_skip", 16'h701E, 3, 3, C_INR);
    AC_ZERO = 1'b0; E_ZERO = 1'b0;

    instr("bun", 16'h4123, 4, 4, C_LD);
    instr("bun_ind", 16'hC123, 4, 4, C_LD);
    instr("bsa", 16'h5123, 5, 5, C_LD);
    DR_ZERO = 1'b1;
    instr("isz_z", 16'h6050, 6, 6, C_INR);
    DR_ZERO = 1'b0;
    instr("isz_nz", 16'h6050, 6, 0, C_NONE);
    instr("sta", 16'h3000, 4, 0, C_NONE);
    instr("lda", 16'h2000, 5, 0, C_NONE);
    instr("add", 16'h1000, 5, 0, C_NONE);
    instr("and_ind", 16'h8000, 5, 0, C_NONE);

    FGI = 1'b1;
    instr("ski_set", 16'hF200, 3, 3, C_INR);
    FGI = 1'b0;
    instr("ski_clr", 16'hF200, 3, 0, C_NONE);
    FGO = 1'b1;
    instr("sko_set", 16'hF100, 3, 3, C_INR);
    FGO = 1'b0;
    instr("sko_clr", 16'hF100, 3, 0, C_NONE);

    instr("ion", 16'hF080, 3, 0, C_NONE);
    ien_e = 1'b1;
    FGI = 1'b1;
    instr("cla_fgi", 16'h7800, 3, 0, C_NONE);
    FGI = 1'b0;
`ifdef INTR_EN
    expect_cyc("rt0", 4'd0, C_NONE, 1'b1, 1'b1);
    expect_cyc("rt1", 4'd1, C_CLR,  1'b1, 1'b1);
    expect_cyc("rt2", 4'd2, C_INR,  1'b1, 1'b1);
    ien_e = 1'b0;
`endif
    instr("iof", 16'hF040, 3, 0, C_NONE);
    ien_e = 1'b0;

    instr("ion2", 16'hF080, 3, 0, C_NONE);
    ien_e = 1'b1;
    IR = 16'h4123;
    expect_cyc("abort.t0", 4'd0, C_AR);
    expect_cyc("abort.t1", 4'd1, C_FETCH);
    expect_cyc("abort.t2", 4'd2, C_NONE);
    expect_cyc("abort.t3", 4'd3, C_NONE);
    CLR = 1'b0;
    ien_e = 1'b0;
    expect_cyc("abort.rst", 4'd0, C_NONE);
    CLR = 1'b1;
    instr("after_abort", 16'h7800, 3, 0, C_NONE);

    instr("hlt", 16'h7001, 3, 0, C_NONE);
    for (int i = 0; i < 20; i++)
      expect_cyc($sformatf("halted%0d", i), 4'd0, C_NONE, 1'b0);
    CLR = 1'b0;
    expect_cyc("hlt.rst", 4'd0, C_NONE);
    CLR = 1'b1;
    instr("after_hlt", 16'h7800, 3, 0, C_NONE);

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
